uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx.sv | 121 ++++++++++++
 tb/tb_uart_rx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial-in / byte-out bundle of the UART debug-link receiver.
// The receiver uses the slave side; the source of rx/s_tick uses the master side.
interface uart_rx_if #(
  parameter int NB_DATA = 8
);
  logic               s_tick;
  logic               rx;
  logic [NB_DATA-1:0] dout;
  logic               rx_done_tick;
  logic               framing_error;

  modport master (
    output s_tick,
    output rx,
    input  dout,
    input  rx_done_tick,
    input  framing_error
  );

  modport slave (
    input  s_tick,
    input  rx,
    output dout,
    output rx_done_tick,
    output framing_error
  );
endinterface

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver driven by a shared 16x oversampling tick.
// Presents each well-framed byte on dout with a one-clock rx_done_tick.
module uart_rx #(
  parameter int NB_DATA     = 8,
  parameter int SB_TICK     = 16,
  parameter int NB_TICK_CNT = 4
) (
  input  logic      clock,
  input  logic      reset,
  uart_rx_if.slave  bus
);
  localparam int NB_BIT_CNT = $clog2(NB_DATA);

  localparam logic [NB_TICK_CNT-1:0] START_MID = NB_TICK_CNT'(7);
  localparam logic [NB_TICK_CNT-1:0] DATA_MID  = NB_TICK_CNT'(15);
  localparam logic [NB_TICK_CNT-1:0] STOP_MID  = NB_TICK_CNT'(SB_TICK - 1);
  localparam logic [NB_BIT_CNT-1:0]  BIT_LAST  = NB_BIT_CNT'(NB_DATA - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state_r;
  logic [NB_TICK_CNT-1:0] s_r;
  logic [NB_BIT_CNT-1:0]  n_r;
  logic [NB_DATA-1:0]     b_r;
  logic [NB_DATA-1:0]     dout_r;
  logic                   done_r;
  logic                   ferr_r;
  logic [1:0]             sync_r;
  logic                   rx_s;

  assign rx_s              = sync_r[1];
  assign bus.dout          = dout_r;
  assign bus.rx_done_tick  = done_r;
  assign bus.framing_error = ferr_r;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], bus.rx};
    end
  end

  // Frame FSM: every sample point sits mid-bit, counted in oversampling ticks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      s_r     <= '0;
      n_r     <= '0;
      b_r     <= '0;
      dout_r  <= '0;
      done_r  <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      ferr_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r <= START;
            s_r     <= '0;
          end
        end
        START: begin
          if (bus.s_tick) begin
            if (s_r == START_MID) begin
              // A line that is high again at mid start bit was only a glitch.
              state_r <= rx_s ? IDLE : DATA;
              s_r     <= '0;
              n_r     <= '0;
            end else begin
              s_r <= s_r + NB_TICK_CNT'(1);
            end
          end
        end
        DATA: begin
          if (bus.s_tick) begin
            if (s_r == DATA_MID) begin
              b_r <= {rx_s, b_r[NB_DATA-1:1]};
              s_r <= '0;
              if (n_r == BIT_LAST) begin
                state_r <= STOP;
              end else begin
                n_r <= n_r + NB_BIT_CNT'(1);
              end
            end else begin
              s_r <= s_r + NB_TICK_CNT'(1);
            end
          end
        end
        STOP: begin
          if (bus.s_tick) begin
            if (s_r == STOP_MID) begin
              if (rx_s) begin
                dout_r <= b_r;
                done_r <= 1'b1;
              end else begin
                ferr_r <= 1'b1;
              end
              state_r <= IDLE;
              s_r     <= '0;
            end else begin
              s_r <= s_r + NB_TICK_CNT'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          s_r     <= '0;
          n_r     <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: a frame-level model predicts
// each pulse and byte, and a per-cycle monitor compares the DUT against it.
module tb_uart_rx;
  localparam int TICK_DIV    = 4;
  localparam int FRAME_TICKS = 8 + 16 * 8 + 16;
  localparam int LATENCY     = FRAME_TICKS * TICK_DIV;

  typedef struct packed {
    logic       fe;
    logic [7:0] data;
  } ev_t;

  logic clock;
  logic reset;
  uart_rx_if #(.NB_DATA(8)) bus ();

  uart_rx #(.NB_DATA(8), .SB_TICK(16), .NB_TICK_CNT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  ev_t        exp_q[$];
  logic [7:0] exp_dout;
  int         n_checks;
  int         n_fail;
  int         n_done;
  int         n_ferr;
  int         n_good_sent;
  int         cyc;
  int         t_fall;
  int         last_lat;

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic ticker();
    int div = 0;
    forever begin
      @(negedge clock);
      div = (div == TICK_DIV - 1) ? 0 : div + 1;
      bus.s_tick = (div == TICK_DIV - 1);
    end
  endtask

  // Compare DUT outputs against the model one time step after every edge.
  task automatic monitor();
    ev_t ev;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        exp_dout = 8'h00;
        check("reset_outputs", 32'({bus.dout, bus.rx_done_tick, bus.framing_error}), 32'h0);
      end else begin
        check("pulse_exclusive", 32'(bus.rx_done_tick & bus.framing_error), 32'h0);
        if (bus.rx_done_tick || bus.framing_error) begin
          if (bus.rx_done_tick) n_done++;
          if (bus.framing_error) n_ferr++;
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'({bus.rx_done_tick, bus.framing_error}), 32'h0);
          end else begin
            ev = exp_q.pop_front();
            check("pulse_kind", 32'({bus.rx_done_tick, bus.framing_error}), 32'({~ev.fe, ev.fe}));
            if (!ev.fe) begin
              exp_dout = ev.data;
              last_lat = cyc - t_fall;
              check("frame_latency", 32'(last_lat), 32'(LATENCY));
            end
          end
        end
        check("dout", 32'(bus.dout), 32'(exp_dout));
      end
    end
  endtask

  task automatic wait_ticks(input int k);
    repeat (k) begin
      @(posedge clock);
      while (bus.s_tick !== 1'b1) @(posedge clock);
      @(negedge clock);
    end
  endtask

  // Plays one 8-N-1 frame; a bad stop bit is held low only through its sample point.
  task automatic send_frame(input logic [7:0] data, input bit stop_ok);
    ev_t ev;
    ev.fe   = ~stop_ok;
    ev.data = data;
    exp_q.push_back(ev);
    if (stop_ok) n_good_sent++;
    t_fall = cyc;
    bus.rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      bus.rx = data[i];
      wait_ticks(16);
    end
    if (stop_ok) begin
      bus.rx = 1'b1;
      wait_ticks(16);
    end else begin
      bus.rx = 1'b0;
      wait_ticks(9);
      bus.rx = 1'b1;
      wait_ticks(7);
    end
    check("frame_resolved", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    logic [7:0] rb;
    bit         ok;
    int         gap;
    clock = 1'b0; reset = 1'b1; bus.rx = 1'b1; bus.s_tick = 1'b0;
    n_checks = 0; n_fail = 0; n_done = 0; n_ferr = 0; n_good_sent = 0;
    cyc = 0; t_fall = 0; last_lat = 0; exp_dout = 8'h00;
    fork
      ticker();
      monitor();
    join_none
    repeat (5) @(negedge clock);
    reset = 1'b0;
    check("reset_dout", 32'(bus.dout), 32'h00);
    check("reset_done", 32'(bus.rx_done_tick), 32'h0);
    check("reset_ferr", 32'(bus.framing_error), 32'h0);
    wait_ticks(2);

    send_frame(8'hAB, 1'b1);
    check("dout_ab", 32'(bus.dout), 32'hAB);
    check("latency_ab", 32'(last_lat), 32'd608);
    check("done_count_ab", 32'(n_done), 32'd1);
    check("ferr_count_ab", 32'(n_ferr), 32'd0);

    bus.rx = 1'b0;
    wait_ticks(4);
    bus.rx = 1'b1;
    wait_ticks(20);
    check("glitch_dout", 32'(bus.dout), 32'hAB);
    check("glitch_pulses", 32'(n_done + n_ferr), 32'd1);

    send_frame(8'h55, 1'b0);
    check("ferr_dout_kept", 32'(bus.dout), 32'hAB);
    check("ferr_count", 32'(n_ferr), 32'd1);
    check("ferr_no_done", 32'(n_done), 32'd1);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    check("b2b_done_count", 32'(n_done), 32'd4);
    check("b2b_dout", 32'(bus.dout), 32'h3C);

    // 0x81 aborted by reset after four data bits; nothing may be reported.
    bus.rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      bus.rx = (i == 0) ? 1'b1 : 1'b0;
      wait_ticks(16);
    end
    reset = 1'b1;
    bus.rx = 1'b1;
    wait_ticks(2);
    check("midreset_dout", 32'(bus.dout), 32'h00);
    reset = 1'b0;
    wait_ticks(20);
    check("midreset_pulses", 32'(n_done + n_ferr), 32'd5);
    send_frame(8'h42, 1'b1);
    check("after_reset_dout", 32'(bus.dout), 32'h42);

    for (int f = 0; f < 30; f++) begin
      rb  = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 4) != 0);
      gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 24);
      send_frame(rb, ok);
      if (gap > 0) wait_ticks(gap);
    end
    wait_ticks(20);
    check("total_done", 32'(n_done), 32'(n_good_sent));
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
